// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter: round-robin burst scheduler feeding one downstream FIFO
// from N_IN AXI-Stream producers. A producer is granted only when the FIFO
// has room for a full burst; the datapath is a zero-latency mux.

// Per-stream ready gating: ready follows the FIFO only for the granted stream
// and is forced low while reset is asserted.
module fifo_burst_arbiter_lane (
    input  logic sel_i,
    input  logic out_ready_i,
    input  logic rst_n_i,
    output logic tready_o
);
    assign tready_o = sel_i & out_ready_i & rst_n_i;
endmodule

module fifo_burst_arbiter #(
    parameter int N_IN       = 4,
    parameter int WIDTH      = 16,
    parameter int BURST      = 4,
    parameter int FIFO_DEPTH = 32,
    parameter int CW         = 6,
    parameter int IDW        = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [N_IN*WIDTH-1:0] in_V_V_TDATA,
    input  logic [N_IN-1:0]       in_V_V_TVALID,
    output logic [N_IN-1:0]       in_V_V_TREADY,
    output logic [WIDTH-1:0]      out_V_V_TDATA,
    output logic                  out_V_V_TVALID,
    input  logic                  out_V_V_TREADY,
    input  logic [CW-1:0]         fifo_count,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t                       state_q, state_d;
    logic [BW-1:0]                beat_q, beat_d;
    logic [IDW-1:0]               last_q, last_d;
    logic [IDW-1:0]               gid_q, gid_d;

    logic [N_IN-1:0][WIDTH-1:0]   in_data;
    logic [CW:0]                  count_x;
    logic [CW:0]                  free_x;
    logic                         space_ok;
    logic                         any_req;
    logic                         found;
    logic [IDW-1:0]               sel;

    assign in_data = in_V_V_TDATA;
    assign any_req = |in_V_V_TVALID;

    // Free-space check at CW+1 bits; an out-of-range count never admits a burst.
    assign count_x  = {1'b0, fifo_count};
    assign free_x   = (CW+1)'(FIFO_DEPTH) - count_x;
    assign space_ok = (count_x <= (CW+1)'(FIFO_DEPTH)) && (free_x >= (CW+1)'(BURST));

    // Round-robin pick: first valid stream after the last one served.
    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= N_IN; k++) begin
            c = (int'(last_q) + k) % N_IN;
            if (!found && in_V_V_TVALID[c[IDW-1:0]]) begin
                found = 1'b1;
                sel   = c[IDW-1:0];
            end
        end
    end

    // State register: FSM, beat counter, round-robin pointer, granted index.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            last_q  <= IDW'(N_IN - 1);
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
        end
    end

    // Next state: admit a grant from IDLE, end it on the last beat or when
    // the granted stream goes quiet; a stalled FIFO simply holds the grant.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        gid_d   = gid_q;
        case (state_q)
            S_IDLE: begin
                if (any_req && space_ok && found) begin
                    state_d = S_GRANT;
                    gid_d   = sel;
                    beat_d  = '0;
                end
            end
            S_GRANT: begin
                if (!in_V_V_TVALID[gid_q]) begin
                    state_d = S_IDLE;
                    last_d  = gid_q;
                    gid_d   = '0;
                    beat_d  = '0;
                end else if (out_V_V_TREADY) begin
                    if (beat_q == BW'(BURST - 1)) begin
                        state_d = S_IDLE;
                        last_d  = gid_q;
                        gid_d   = '0;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: mux the granted stream through; valid is forced low in reset.
    always_comb begin
        busy           = (state_q == S_GRANT);
        grant_id       = gid_q;
        out_V_V_TDATA  = busy ? in_data[gid_q] : '0;
        out_V_V_TVALID = busy & in_V_V_TVALID[gid_q] & ap_rst_n;
    end

    genvar i;
    for (i = 0; i < N_IN; i++) begin : g_lane
        fifo_burst_arbiter_lane u_lane (
            .sel_i       ((state_q == S_GRANT) && (gid_q == IDW'(i))),
            .out_ready_i (out_V_V_TREADY),
            .rst_n_i     (ap_rst_n),
            .tready_o    (in_V_V_TREADY[i])
        );
    end

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Bench for fifo_burst_arbiter: directed scenarios followed by a random
// phase, every cycle compared against a burst-level reference model.
module tb_fifo_burst_arbiter;
    localparam int N = 4, W = 16, B = 4, D = 32, CW = 6, IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*W-1:0]    tdata;
    logic [N-1:0]      vld = '0;
    logic [N-1:0]      trdy;
    logic [W-1:0]      odata;
    logic              ovld;
    logic              ordy = 1'b1;
    logic [CW-1:0]     fcnt = '0;
    logic [IDW-1:0]    gid;
    logic              busy;

    int checks = 0;
    int failures = 0;

    // reference model: who holds the grant and how many beats it has moved
    bit m_busy;
    int m_g, m_beats, m_last;
    int seq[N];
    int beats[N];
    int q_grants[$];
    logic [W-1:0] q_data[$];

    fifo_burst_arbiter #(.N_IN(N), .WIDTH(W), .BURST(B), .FIFO_DEPTH(D), .CW(CW), .IDW(IDW)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_V_V_TDATA(tdata), .in_V_V_TVALID(vld), .in_V_V_TREADY(trdy),
        .out_V_V_TDATA(odata), .out_V_V_TVALID(ovld), .out_V_V_TREADY(ordy),
        .fifo_count(fcnt), .grant_id(gid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++)
            tdata[i*W +: W] = {4'(i), 12'(seq[i])};
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the
    // model with the inputs that were present at the rising edge.
    task automatic cyc();
        logic [N-1:0] e_rdy;
        logic [W-1:0] e_data;
        bit hs[N];
        int c;
        drive_data();
        #1;
        e_rdy = '0;
        if (rst_n && m_busy) e_rdy[m_g] = ordy;
        e_data = m_busy ? tdata[m_g*W +: W] : '0;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(gid), m_busy ? m_g : 0);
        chk("out_tvalid", 32'(ovld), 32'(rst_n && m_busy && vld[m_g]));
        chk("in_tready", 32'(trdy), 32'(e_rdy));
        chk("out_tdata", 32'(odata), 32'(e_data));
        for (int i = 0; i < N; i++) hs[i] = trdy[i] && vld[i];
        if (ovld && ordy) q_data.push_back(odata);
        @(posedge clk);
        for (int i = 0; i < N; i++) if (hs[i]) begin seq[i]++; beats[i]++; end
        if (!rst_n) begin
            m_busy = 0; m_g = 0; m_beats = 0; m_last = N - 1;
        end else if (!m_busy) begin
            if (int'(fcnt) <= D && D - int'(fcnt) >= B && vld != 0) begin
                for (int k = N; k >= 1; k--) begin
                    c = (m_last + k) % N;
                    if (vld[c]) m_g = c;
                end
                m_busy = 1; m_beats = 0;
                q_grants.push_back(m_g);
            end
        end else if (!vld[m_g]) begin
            m_busy = 0; m_last = m_g; m_g = 0; m_beats = 0;
        end else if (ordy) begin
            m_beats++;
            if (m_beats == B) begin m_busy = 0; m_last = m_g; m_g = 0; m_beats = 0; end
        end
        @(negedge clk);
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        q_grants.delete();
        q_data.delete();
        for (int i = 0; i < N; i++) beats[i] = 0;
    endtask

    initial begin
        int n[N];
        int order[5];
        m_busy = 0; m_g = 0; m_beats = 0; m_last = N - 1;
        for (int i = 0; i < N; i++) begin seq[i] = 0; beats[i] = 0; end
        drive_data();
        repeat (2) @(negedge clk);

        // reset release with streams 0 and 2 requesting
        vld = 4'b0101; ordy = 1; fcnt = 0;
        reset_seq();
        chk("s1_reset_busy", 32'(busy), 0);
        chk("s1_reset_tready", 32'(trdy), 0);
        cyc();
        chk("s1_first_gid", 32'(gid), 0);
        chk("s1_first_busy", 32'(busy), 1);
        repeat (9) cyc();
        chk("s1_grants", 32'(q_grants.size()), 2);
        if (q_grants.size() == 2) begin
            chk("s1_g0", 32'(q_grants[0]), 0);
            chk("s1_g1", 32'(q_grants[1]), 2);
        end
        chk("s1_beats0", 32'(beats[0]), 4);
        chk("s1_beats2", 32'(beats[2]), 4);

        // all streams requesting: full rotation with one gap per burst
        vld = 4'b1111;
        reset_seq();
        for (int i = 0; i < N; i++) n[i] = seq[i];
        repeat (25) cyc();
        order = '{0, 1, 2, 3, 0};
        chk("s2_grants", 32'(q_grants.size()), 5);
        chk("s2_words", 32'(q_data.size()), 20);
        for (int b = 0; b < 5; b++) begin
            if (b < q_grants.size()) chk("s2_order", 32'(q_grants[b]), 32'(order[b]));
            for (int j = 0; j < 4; j++) begin
                if (b*4 + j < q_data.size())
                    chk("s2_data", 32'(q_data[b*4+j]), 32'({4'(order[b]), 12'(n[order[b]])}));
                n[order[b]]++;
            end
        end
        chk("s2_gap_busy", 32'(busy), 0);

        // FIFO nearly full: no grant until a full burst fits
        vld = 4'b0010; fcnt = 29;
        reset_seq();
        repeat (3) cyc();
        chk("s3_blocked_busy", 32'(busy), 0);
        chk("s3_blocked_tready", 32'(trdy), 0);
        fcnt = 28;
        cyc();
        chk("s3_grant_busy", 32'(busy), 1);
        chk("s3_grant_gid", 32'(gid), 1);
        fcnt = 0;

        // stream 3 releases early; next scan starts at stream 0
        vld = 4'b1000;
        reset_seq();
        repeat (3) cyc();
        vld = 4'b0001;
        cyc();
        chk("s4_released", 32'(busy), 0);
        cyc();
        chk("s4_beats3", 32'(beats[3]), 2);
        chk("s4_next_gid", 32'(gid), 0);

        // FIFO stalls mid-burst for 5 cycles
        vld = 4'b0100;
        reset_seq();
        repeat (3) cyc();
        ordy = 0;
        repeat (5) cyc();
        chk("s5_hold_busy", 32'(busy), 1);
        chk("s5_hold_beats", 32'(beats[2]), 2);
        ordy = 1;
        repeat (2) cyc();
        chk("s5_beats2", 32'(beats[2]), 4);
        chk("s5_idle", 32'(busy), 0);

        // reset pulse after two beats of a stream 2 burst
        vld = 4'b0100;
        reset_seq();
        repeat (3) cyc();
        vld = 4'b1110;
        rst_n = 0;
        cyc();
        chk("s6_rst_busy", 32'(busy), 0);
        rst_n = 1;
        cyc();
        chk("s6_gid", 32'(gid), 1);
        chk("s6_beats2", 32'(beats[2]), 2);

        // random traffic against the model
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < N; i++) vld[i] = ($urandom_range(0, 9) < 7);
            ordy  = ($urandom_range(0, 3) != 0);
            fcnt  = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(26, 40)) : CW'($urandom_range(0, 27));
            rst_n = ($urandom_range(0, 59) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
